// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: scanout, CPU and VRAM-macro signals of the VRAM arbiter.
interface vram_arbiter_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          vid_late;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_q;
    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
        output vid_data, vid_valid, vid_late, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata
    );
    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
        input  vid_data, vid_valid, vid_late, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: one VRAM slot per clk, video reads first, CPU req/ack behind them.
// Define VRAM_STARVE_GUARD_EN to force a CPU slot after MAX_CPU_WAIT pending cycles.
module vram_arbiter #(
    parameter int AW = 13,
    parameter int DW = 8,
    parameter int MAX_CPU_WAIT = 8
) (
    input logic clk,
    input logic rst_n,
    vram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {C_IDLE, C_PEND, C_DATA, C_ACK} cpu_state_t;
    cpu_state_t state;
    logic s1_vid, s2_vid, s1_late, s2_late;
    logic vid_go, cpu_go, late_go;
    logic [AW-1:0] vid_go_addr, cpu_addr_q;
    logic [DW-1:0] cpu_wdata_q, rdata_q;
    logic cpu_we_q;
    if (MAX_CPU_WAIT < 1) begin : g_bad_wait
        $error("MAX_CPU_WAIT must be at least 1");
    end
`ifdef VRAM_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_CPU_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_CPU_WAIT);
    logic [CW-1:0] wait_cnt;
    logic vid_hold, force_cpu;
    logic [AW-1:0] hold_addr;
    assign force_cpu = state == C_PEND && wait_cnt >= WAIT_MAX;
    // A deferred video read takes the next slot; a new request arriving then is deferred in turn.
    assign vid_go = !force_cpu && (vid_hold || bus.vid_req);
    assign vid_go_addr = vid_hold ? hold_addr : bus.vid_addr;
    assign late_go = vid_hold;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wait_cnt <= '0;
            vid_hold <= 1'b0;
            hold_addr <= '0;
        end else begin
            wait_cnt <= (state != C_PEND || cpu_go) ? '0 : (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + CW'(1);
            vid_hold <= bus.vid_req && (force_cpu || vid_hold);
            if (bus.vid_req) hold_addr <= bus.vid_addr;
        end
`else
    assign vid_go = bus.vid_req;
    assign vid_go_addr = bus.vid_addr;
    assign late_go = 1'b0;
`endif
    assign cpu_go = state == C_PEND && !vid_go;
    assign bus.cpu_ack = state == C_ACK;
    // ram_q of a CPU read arrives in the ack cycle, so it is forwarded then and held afterwards.
    assign bus.cpu_rdata = (bus.cpu_ack && !cpu_we_q) ? bus.ram_q : rdata_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= C_IDLE;
            {s1_vid, s2_vid, s1_late, s2_late} <= '0;
            cpu_we_q <= 1'b0;
            cpu_addr_q <= '0;
            cpu_wdata_q <= '0;
            rdata_q <= '0;
            bus.vid_valid <= 1'b0;
            bus.vid_late <= 1'b0;
            bus.vid_data <= '0;
            bus.ram_addr <= '0;
            bus.ram_we <= 1'b0;
            bus.ram_wdata <= '0;
        end else begin
            s1_vid <= vid_go;
            s2_vid <= s1_vid;
            s1_late <= late_go;
            s2_late <= s1_late;
            bus.vid_valid <= s2_vid;
            bus.vid_late <= s2_vid && s2_late;
            if (s2_vid) bus.vid_data <= bus.ram_q;
            bus.ram_we <= cpu_go && cpu_we_q;
            if (vid_go) bus.ram_addr <= vid_go_addr;
            else if (cpu_go) bus.ram_addr <= cpu_addr_q;
            if (cpu_go && cpu_we_q) bus.ram_wdata <= cpu_wdata_q;
            if (state == C_ACK && !cpu_we_q) rdata_q <= bus.ram_q;
            // Capture the request so an early-dropped cpu_req still completes.
            if (state == C_IDLE) {cpu_we_q, cpu_addr_q, cpu_wdata_q} <= {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};
            case (state)
                C_IDLE:  state <= bus.cpu_req ? C_PEND : C_IDLE;
                C_PEND:  state <= !cpu_go ? C_PEND : cpu_we_q ? C_ACK : C_DATA;
                C_DATA:  state <= C_ACK;
                default: state <= C_IDLE;
            endcase
        end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scenario tasks plus a cycle-level slot-order model of the arbiter.
`timescale 1ns/1ps
module tb_vram_arbiter;
    localparam int AW = 13;
    localparam int DW = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    vram_arbiter #(.AW(AW), .DW(DW), .MAX_CPU_WAIT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] mm [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_q <= ram[bus.ram_addr];
    end

    // Model: video takes every slot it asks for; a pending CPU access takes the first free slot
    // after the cycle its request was seen; RAM contents follow slot order.
    typedef struct { int due; logic [DW-1:0] d; } vexp_t;
    vexp_t vq[$];
    int cyc = 0;
    bit cb, cgr, cwe;
    int cstart, cdue;
    logic [AW-1:0] ca, ra_e;
    logic [DW-1:0] cw, crd, wd_e;
    logic we_e;
`ifndef VRAM_STARVE_GUARD_EN
    always @(negedge clk) begin
        bit exp_v, exp_a;
        cyc++;
        if (!rst_n) begin
            vq.delete();
            cb = 0;
            ra_e = '0;
            we_e = 1'b0;
            wd_e = '0;
        end else begin
            exp_v = vq.size() > 0 && vq[0].due == cyc;
            n_cmp++;
            if (bus.vid_valid !== exp_v) begin n_err++; $display("FAIL vid_valid cyc=%0d got=%b exp=%b", cyc, bus.vid_valid, exp_v); end
            if (exp_v) begin
                n_cmp++;
                if (bus.vid_data !== vq[0].d) begin n_err++; $display("FAIL vid_data cyc=%0d got=%h exp=%h", cyc, bus.vid_data, vq[0].d); end
                void'(vq.pop_front());
            end
            n_cmp++;
            if (bus.vid_late !== 1'b0) begin n_err++; $display("FAIL vid_late cyc=%0d got=%b exp=0", cyc, bus.vid_late); end
            exp_a = cb && cgr && cdue == cyc;
            n_cmp++;
            if (bus.cpu_ack !== exp_a) begin n_err++; $display("FAIL cpu_ack cyc=%0d got=%b exp=%b", cyc, bus.cpu_ack, exp_a); end
            if (exp_a && !cwe) begin
                n_cmp++;
                if (bus.cpu_rdata !== crd) begin n_err++; $display("FAIL cpu_rdata cyc=%0d got=%h exp=%h", cyc, bus.cpu_rdata, crd); end
            end
            n_cmp++;
            if ({bus.ram_we, bus.ram_addr} !== {we_e, ra_e} || (we_e && bus.ram_wdata !== wd_e)) begin
                n_err++;
                $display("FAIL ram_port cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, bus.ram_we, bus.ram_addr, bus.ram_wdata, we_e, ra_e, wd_e);
            end
            we_e = 1'b0;
            if (cb && cgr && cyc > cdue) cb = 0;
            if (!cb && bus.cpu_req) begin
                cb = 1; cgr = 0; cwe = bus.cpu_we; ca = bus.cpu_addr; cw = bus.cpu_wdata; cstart = cyc + 1;
            end else if (cb && !cgr && cyc >= cstart && !bus.vid_req) begin
                cgr = 1;
                ra_e = ca;
                if (cwe) begin mm[ca] = cw; we_e = 1'b1; wd_e = cw; cdue = cyc + 1; end
                else begin crd = mm[ca]; cdue = cyc + 2; end
            end
            if (bus.vid_req) begin
                vq.push_back('{due: cyc + 3, d: mm[bus.vid_addr]});
                ra_e = bus.vid_addr;
            end
        end
    end
`endif

    task automatic test_reset();
        int bad = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.vid_valid, bus.vid_late, bus.cpu_ack, bus.ram_we, bus.vid_data, bus.cpu_rdata, bus.ram_addr, bus.ram_wdata} !== '0) begin
            n_err++; $display("FAIL reset_outputs got=%b/%b/%b/%b/%h/%h/%h/%h exp=all 0", bus.vid_valid, bus.vid_late, bus.cpu_ack, bus.ram_we, bus.vid_data, bus.cpu_rdata, bus.ram_addr, bus.ram_wdata);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0055; bus.vid_req = 1'b1; bus.vid_addr = 13'h0030;
        @(posedge clk); #1 bus.vid_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0; bus.cpu_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.vid_valid, bus.vid_late, bus.cpu_ack, bus.ram_we, bus.vid_data, bus.cpu_rdata, bus.ram_addr, bus.ram_wdata} !== '0) begin
            n_err++; $display("FAIL midop_reset got=%b/%b/%b/%b/%h/%h/%h/%h exp=all 0", bus.vid_valid, bus.vid_late, bus.cpu_ack, bus.ram_we, bus.vid_data, bus.cpu_rdata, bus.ram_addr, bus.ram_wdata);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) begin @(negedge clk); if (bus.cpu_ack || bus.vid_valid) bad++; end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL reset_no_stale got=%0d pulses exp=0", bad); end
    endtask

    task automatic test_video_read();
        @(posedge clk); #1 bus.vid_req = 1'b1; bus.vid_addr = 13'h0030;
        @(posedge clk); #1 bus.vid_req = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (bus.vid_valid !== 1'b0) begin n_err++; $display("FAIL vid_early got=%b exp=0", bus.vid_valid); end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({bus.vid_valid, bus.vid_data} !== {1'b1, 8'hA5}) begin n_err++; $display("FAIL vid_lat3 got=%b/%h exp=1/a5", bus.vid_valid, bus.vid_data); end
    endtask

    task automatic test_cpu_write_read();
        int lat;
        @(posedge clk); #1 bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h1FFF; bus.cpu_wdata = 8'h3C;
        lat = 0;
        @(negedge clk);
        while (!bus.cpu_ack && lat < 30) begin @(negedge clk); lat++; end
        n_cmp++;
        if (lat != 2) begin n_err++; $display("FAIL write_ack_lat got=%0d exp=2", lat); end
        @(posedge clk); #1 bus.cpu_req = 1'b0;
        @(posedge clk); #1 bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.cpu_ack && lat < 30) begin @(negedge clk); lat++; end
        n_cmp++;
        if (lat != 3 || bus.cpu_rdata !== 8'h3C) begin n_err++; $display("FAIL read_ack got lat=%0d data=%h exp lat=3 data=3c", lat, bus.cpu_rdata); end
        @(posedge clk); #1 bus.cpu_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.cpu_rdata !== 8'h3C) begin n_err++; $display("FAIL rdata_hold got=%h exp=3c", bus.cpu_rdata); end
    endtask

    task automatic test_video_starve();
        int lat = -1, acks = 0, lates = 0;
        @(posedge clk); #1 bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = AW'($urandom);
        for (int k = 0; k < 30; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (lat >= 0) bus.cpu_req = 1'b0;
            bus.vid_req = k < 20;
            bus.vid_addr = AW'($urandom);
            @(negedge clk);
            if (bus.vid_late) lates++;
            if (bus.cpu_ack) begin acks++; if (lat < 0) lat = k; end
        end
        @(posedge clk); #1 bus.cpu_req = 1'b0;
        n_cmp++;
        if (acks != 1) begin n_err++; $display("FAIL starve_acks got=%0d exp=1", acks); end
`ifdef VRAM_STARVE_GUARD_EN
        n_cmp++;
        if (lat < 1 || lat > 11 || lates < 1) begin n_err++; $display("FAIL starve_guard got lat=%0d late=%0d exp lat<=11 late>=1", lat, lates); end
`else
        n_cmp++;
        if (lat != 22 || lates != 0) begin n_err++; $display("FAIL starve_wait got lat=%0d late=%0d exp lat=22 late=0", lat, lates); end
`endif
    endtask

    task automatic test_write_video_race();
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0100; bus.cpu_wdata = 8'h77;
        bus.vid_req = 1'b1; bus.vid_addr = 13'h0100;
        @(posedge clk); #1 bus.vid_req = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (bus.cpu_ack !== 1'b1) begin n_err++; $display("FAIL race_ack got=%b exp=1", bus.cpu_ack); end
        @(posedge clk); #1 bus.cpu_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.vid_valid, bus.vid_data} !== {1'b1, 8'h11}) begin n_err++; $display("FAIL race_old got=%b/%h exp=1/11", bus.vid_valid, bus.vid_data); end
        @(posedge clk); #1 bus.vid_req = 1'b1; bus.vid_addr = 13'h0100;
        @(posedge clk); #1 bus.vid_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.vid_valid, bus.vid_data} !== {1'b1, 8'h77}) begin n_err++; $display("FAIL race_new got=%b/%h exp=1/77", bus.vid_valid, bus.vid_data); end
    endtask

    task automatic test_back_to_back();
        int acks = 0, last = -100, extra = 0;
        bit gap_ok = 1;
        @(posedge clk); #1 bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = AW'($urandom);
        for (int k = 0; k < 120 && acks < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            bus.vid_req = 1'($urandom_range(0, 1));
            bus.vid_addr = AW'($urandom);
            @(negedge clk);
            if (bus.cpu_ack) begin if (k - last < 4) gap_ok = 0; last = k; acks++; end
        end
        @(posedge clk); #1 bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        n_cmp++;
        if (acks != 4 || !gap_ok) begin n_err++; $display("FAIL b2b_acks got=%0d gap_ok=%b exp=4/1", acks, gap_ok); end
        repeat (10) begin @(negedge clk); if (bus.cpu_ack) extra++; end
        n_cmp++;
        if (extra != 0) begin n_err++; $display("FAIL b2b_dup got=%0d exp=0", extra); end
    endtask

    task automatic test_random();
        bit active = 0, ack_prev = 0;
        int started = 0, acked = 0;
        for (int k = 0; k < 400 || (active && k < 460); k++) begin
            @(posedge clk); #1;
            bus.vid_req = k < 400 && $urandom_range(0, 2) == 0;
            bus.vid_addr = {($urandom_range(0, 1) == 1) ? 9'h1FF : 9'h000, 4'($urandom)};
            if (ack_prev) begin bus.cpu_req = 1'b0; active = 0; end
            else if (active && bus.cpu_req && $urandom_range(0, 9) == 0) bus.cpu_req = 1'b0;
            else if (!active && k < 400 && $urandom_range(0, 2) == 0) begin
                active = 1; started++;
                bus.cpu_req = 1'b1; bus.cpu_we = 1'($urandom_range(0, 1));
                bus.cpu_addr = {($urandom_range(0, 1) == 1) ? 9'h1FF : 9'h000, 4'($urandom)};
                bus.cpu_wdata = DW'($urandom);
            end
            @(negedge clk);
            ack_prev = bus.cpu_ack;
            if (ack_prev) acked++;
        end
        @(posedge clk); #1 bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        repeat (4) @(posedge clk);
        n_cmp++;
        if (acked != started || active) begin n_err++; $display("FAIL random_txn got=%0d acks exp=%0d", acked, started); end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin ram[i] = DW'($urandom); mm[i] = ram[i]; end
        ram[13'h0030] = 8'hA5; mm[13'h0030] = 8'hA5;
        ram[13'h0100] = 8'h11; mm[13'h0100] = 8'h11;
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        test_reset();
        test_video_read();
        test_cpu_write_read();
        test_video_starve();
        test_write_video_race();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
